// File: rtl/vedic_pkg.sv
// Shared types and constants for the Vedic multiplier arbiter.
// Tag bundle and index-width helper used by the FFT-stage schedulers.
package vedic_pkg;

    localparam int DW          = 24;
    localparam int MUL_LAT_DEF = 3;
    localparam int IDW_MAX     = 3;

    function automatic int idw_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic               vld;
        logic [IDW_MAX-1:0] id;
    } tag_t;

endpackage

// File: rtl/vedic_mul_arbiter_if.sv
// Requester-side bundle of the shared multiplier:
// operand requests in, one-hot grants and product responses out.
interface vedic_mul_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 24,
    parameter int IDW   = 2
);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*DW-1:0] req_a;
    logic [N_REQ*DW-1:0] req_b;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    rsp_valid;
    logic [DW-1:0]       rsp_data;
    logic [IDW-1:0]      rsp_id;

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_id
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_id
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set bit of req
// at or after ptr wins, reported one-hot and as an index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    int   idx;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/vedic_mul_arbiter.sv
// Round-robin sharing of one pipelined 24x24 Vedic multiplier,
// with a tag pipe that routes each product back to its requester.
module vedic_mul_arbiter
    import vedic_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DW      = vedic_pkg::DW,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int IDW     = idw_f(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    vedic_mul_arbiter_if.slave  bus,
    output logic [DW-1:0]       mul_a,
    output logic [DW-1:0]       mul_b,
    input  logic [DW-1:0]       mul_c,
    output logic                busy
);

    localparam int CW = $clog2(MUL_LAT + 2);

    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   win;
    logic             xfer;
    logic             resp;
    tag_t             last;

    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DW-1:0]    hold_a_q, hold_a_d;
    logic [DW-1:0]    hold_b_q, hold_b_d;
    tag_t             tag_q [MUL_LAT];
    tag_t             tag_d [MUL_LAT];
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [DW-1:0]    rsp_data_q, rsp_data_d;
    logic [CW-1:0]    count_q, count_d;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IDW)
    ) u_rr (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (win)
    );

    assign bus.req_ready = gnt;
    assign xfer          = |gnt;
    assign last          = tag_q[MUL_LAT-1];
    assign resp          = |rsp_valid_q;

    always_comb begin
        mul_a    = hold_a_q;
        mul_b    = hold_b_q;
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            mul_a = bus.req_a[win*DW +: DW];
            mul_b = bus.req_b[win*DW +: DW];
            if (win == IDW'(N_REQ - 1))
                rr_ptr_d = '0;
            else
                rr_ptr_d = win + 1'b1;
        end
        hold_a_d = mul_a;
        hold_b_d = mul_b;
    end

    // Stage 0 records every cycle, idle cycles included, as a bubble.
    always_comb begin
        tag_d[0].vld = xfer;
        tag_d[0].id  = IDW_MAX'(win);
        for (int i = 1; i < MUL_LAT; i++)
            tag_d[i] = tag_q[i-1];
    end

    always_comb begin
        rsp_valid_d = '0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (last.vld) begin
            for (int i = 0; i < N_REQ; i++)
                rsp_valid_d[i] = (last.id == IDW_MAX'(i));
            rsp_id_d   = last.id[IDW-1:0];
            rsp_data_d = mul_c;
        end
        count_d = count_q + CW'(xfer) - CW'(resp);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            hold_a_q    <= '0;
            hold_b_q    <= '0;
            rsp_valid_q <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            count_q     <= '0;
            for (int i = 0; i < MUL_LAT; i++)
                tag_q[i] <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            hold_a_q    <= hold_a_d;
            hold_b_q    <= hold_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            count_q     <= count_d;
            for (int i = 0; i < MUL_LAT; i++)
                tag_q[i] <= tag_d[i];
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = (count_q != '0);

endmodule
